// File: rtl/gf22_sram64_be_ctrl.sv
// ---------------------------------------------------------------------------------------------
// gf22_sram64_be_ctrl
//
// Arbitrates one write port and one read port onto a dual-port 64-bit SRAM macro (port 0 write,
// port 1 read) and buffers read data in a small response FIFO with credit-based flow control.
//
// Ports
//   CLK, RSTN                 clock, asynchronous active-low reset
//   wr_valid/wr_ready         write request handshake; wr_addr, wr_data, wr_mask (per-bit enable)
//   rd_valid/rd_ready         read request handshake; rd_addr
//   rsp_valid/rsp_ready       read response handshake; rsp_data
//   CE0, A0, D0, WE0, WEM0    memory write port (driven only on a write grant)
//   CE1, A1                   memory read port (driven only on a read grant)
//   Q1                        memory read data, valid the cycle after CE1
//   conflict_cnt              saturating count of same-bank collision cycles
//
// Address bits [15:13] select the bank. When both requests are eligible and hit the same bank,
// a round-robin flag picks the winner; the flag flips on every collision.
// ---------------------------------------------------------------------------------------------
module gf22_sram64_be_ctrl #(
    parameter int unsigned RSP_DEPTH = 3
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_addr,
    input  logic [63:0] wr_data,
    input  logic [63:0] wr_mask,
    input  logic        rd_valid,
    output logic        rd_ready,
    input  logic [15:0] rd_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        CE0,
    output logic [15:0] A0,
    output logic [63:0] D0,
    output logic        WE0,
    output logic [63:0] WEM0,
    output logic        CE1,
    output logic [15:0] A1,
    input  logic [63:0] Q1,
    output logic [15:0] conflict_cnt
);

    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PW = $clog2(RSP_DEPTH);
    localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(RSP_DEPTH);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(RSP_DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(RSP_DEPTH - 1);

    logic [63:0]   r_mem [RSP_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_inflight;
    logic          r_prio;
    logic [15:0]   r_conflict_cnt;

    logic          w_rd_elig;
    logic          w_collide;
    logic          w_wr_gnt;
    logic          w_rd_gnt;
    logic          w_push;
    logic          w_pop;
    logic [CW:0]   w_credits_used;

    // ---------------------------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------------------------
    // A read is only issued if a FIFO slot is guaranteed for its data, counting the read
    // already in the memory pipeline. This keeps rd_ready independent of rsp_ready.
    assign w_credits_used = {1'b0, r_count} + (CW + 1)'(r_inflight);
    assign w_rd_elig      = rd_valid && (w_credits_used < DEPTH_EXT);
    assign w_collide      = wr_valid && w_rd_elig && (wr_addr[15:13] == rd_addr[15:13]);

    // r_prio == 0: write wins a collision; r_prio == 1: read wins.
    assign w_wr_gnt = wr_valid && !(w_collide && r_prio);
    assign w_rd_gnt = w_rd_elig && !(w_collide && !r_prio);

    assign wr_ready = w_wr_gnt;
    assign rd_ready = w_rd_gnt;

    always_comb begin
        CE0  = 1'b0;
        WE0  = 1'b0;
        A0   = '0;
        D0   = '0;
        WEM0 = '0;
        CE1  = 1'b0;
        A1   = '0;
        if (w_wr_gnt) begin
            CE0  = 1'b1;
            WE0  = 1'b1;
            A0   = wr_addr;
            D0   = wr_data;
            WEM0 = wr_mask;
        end
        if (w_rd_gnt) begin
            CE1 = 1'b1;
            A1  = rd_addr;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_prio         <= 1'b0;
            r_conflict_cnt <= '0;
            r_inflight     <= 1'b0;
        end else begin
            r_inflight <= w_rd_gnt;
            if (w_collide) begin
                r_prio <= ~r_prio;
                if (r_conflict_cnt != 16'hFFFF) begin
                    r_conflict_cnt <= r_conflict_cnt + 16'd1;
                end
            end
        end
    end

    assign conflict_cnt = r_conflict_cnt;

    // ---------------------------------------------------------------------------------------
    // Response FIFO
    // ---------------------------------------------------------------------------------------
    // Q1 belongs to the read issued last cycle, so r_inflight marks it for capture.
    assign w_push = r_inflight;
    assign w_pop  = rsp_valid && rsp_ready;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Storage is qualified by r_count, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= Q1;
        end
    end

    assign rsp_valid = (r_count != '0);
    assign rsp_data  = rsp_valid ? r_mem[r_rptr] : '0;

    // The credit check above must make this unreachable.
    assert property (@(posedge CLK) disable iff (!RSTN)
        !(w_push && !w_pop && (r_count == DEPTH_CNT)))
        else $error("gf22_sram64_be_ctrl: push into full response FIFO");

endmodule
